// File: rtl/md_defs.sv
// md_defs: shared op encoding, FSM states and default latencies for the mul/div unit.
package md_defs;
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;
  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;
endpackage

// File: rtl/md_core.sv
// md_core: combinational 64-bit {HI,LO} result for MULT/MULTU/DIV/DIVU.
module md_core
  import md_defs::*;
(
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [63:0] o_result,
  output logic        o_div_zero
);
  logic [63:0] w_smul, w_umul;
  logic [31:0] w_abs_a, w_abs_b, w_q, w_r, w_hi, w_lo;
  logic        w_sgn, w_bz, w_ovf;
  assign w_smul = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
  assign w_umul = {32'b0, i_a} * {32'b0, i_b};
  assign w_sgn = i_op == OP_DIV;
  assign w_bz = i_b == 32'd0;
  assign w_ovf = w_sgn && i_a == 32'h8000_0000 && i_b == 32'hFFFF_FFFF;
  // Divide on magnitudes, then restore signs: quotient truncates toward zero, remainder follows dividend.
  assign w_abs_a = (w_sgn && i_a[31]) ? -i_a : i_a;
  assign w_abs_b = (w_sgn && i_b[31]) ? -i_b : i_b;
  assign w_q = w_bz ? 32'd0 : w_abs_a / w_abs_b;
  assign w_r = w_bz ? 32'd0 : w_abs_a % w_abs_b;
  assign w_lo = (w_sgn && (i_a[31] ^ i_b[31])) ? -w_q : w_q;
  assign w_hi = (w_sgn && i_a[31]) ? -w_r : w_r;
  assign o_div_zero = (i_op == OP_DIV || i_op == OP_DIVU) && w_bz;
  assign o_result = i_op == OP_MULT  ? w_smul :
                    i_op == OP_MULTU ? w_umul :
                    w_ovf            ? {32'd0, 32'h8000_0000} : {w_hi, w_lo};
endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO owner and fixed-latency mul/div sequencer for the E stage.
module muldiv_ctrl
  import md_defs::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        cancel,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);
  state_t      r_state, w_state_n;
  logic [5:0]  r_cnt, w_cnt_n;
  logic [31:0] r_res_hi, r_res_lo, r_hi, r_lo, w_res_hi_n, w_res_lo_n, w_hi_n, w_lo_n;
  logic        r_skip, w_skip_n, w_div_zero;
  logic [63:0] w_result;
  md_core u_core (
    .i_op      (md_op),
    .i_a       (rs_val),
    .i_b       (rt_val),
    .o_result  (w_result),
    .o_div_zero(w_div_zero)
  );
  assign start  = op_valid && !md_op[2] && r_state == ST_IDLE && !cancel;
  assign busy   = r_state == ST_BUSY;
  assign hi_out = r_hi;
  assign lo_out = r_lo;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 6'd0;
      r_res_hi <= 32'd0;
      r_res_lo <= 32'd0;
      r_skip   <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else begin
      r_state  <= w_state_n;
      r_cnt    <= w_cnt_n;
      r_res_hi <= w_res_hi_n;
      r_res_lo <= w_res_lo_n;
      r_skip   <= w_skip_n;
      r_hi     <= w_hi_n;
      r_lo     <= w_lo_n;
    end
  end
  always_comb begin
    w_state_n  = r_state;
    w_cnt_n    = r_cnt;
    w_res_hi_n = r_res_hi;
    w_res_lo_n = r_res_lo;
    w_skip_n   = r_skip;
    w_hi_n     = r_hi;
    w_lo_n     = r_lo;
    if (r_state == ST_IDLE) begin
      if (start) begin
        w_state_n  = ST_BUSY;
        w_cnt_n    = md_op[1] ? 6'(DIV_CYCLES) : 6'(MULT_CYCLES);
        w_res_hi_n = w_result[63:32];
        w_res_lo_n = w_result[31:0];
        w_skip_n   = w_div_zero;
      end else if (op_valid && !cancel) begin
        w_hi_n = md_op == OP_MTHI ? rs_val : r_hi;
        w_lo_n = md_op == OP_MTLO ? rs_val : r_lo;
      end
    end else if (cancel) begin
      w_state_n = ST_IDLE;
      w_cnt_n   = 6'd0;
    end else begin
      // Divide-by-zero still burns the full latency but leaves HI/LO untouched.
      w_cnt_n = r_cnt - 6'd1;
      if (r_cnt == 6'd1) begin
        w_state_n = ST_IDLE;
        w_hi_n    = r_skip ? r_hi : r_res_hi;
        w_lo_n    = r_skip ? r_lo : r_res_lo;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed and randomized checks of muldiv_ctrl against an arithmetic reference model.
module tb_muldiv_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        cancel = 1'b0;
  logic        start, busy;
  logic [31:0] hi_out, lo_out;
  int errors = 0;
  int checks = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  muldiv_ctrl dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .md_op(md_op),
    .rs_val(rs_val), .rt_val(rt_val), .cancel(cancel),
    .start(start), .busy(busy), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference arithmetic: native 64-bit SV math, independent of the RTL's magnitude/sign scheme.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo, output int n);
    longint sa, sb, p, q, r;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = m_hi;
    lo = m_lo;
    n = (op < 3'd2) ? 5 : 10;
    if (op == 3'd0) begin
      p = sa * sb;
      hi = p[63:32];
      lo = p[31:0];
    end else if (op == 3'd1) begin
      up = 64'(a) * 64'(b);
      hi = up[63:32];
      lo = up[31:0];
    end else if (op == 3'd2 && b != 0) begin
      q = sa / sb;
      r = sa % sb;
      hi = r[31:0];
      lo = q[31:0];
    end else if (op == 3'd3 && b != 0) begin
      hi = a % b;
      lo = a / b;
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh, el;
    int n, cnt;
    model(op, a, b, eh, el, n);
    op_valid = 1'b1;
    md_op = op;
    rs_val = a;
    rt_val = b;
    #1;
    checks++;
    if (start !== (op < 3'd4)) begin
      errors++;
      $display("FAIL %s start: got %b want %b", name, start, op < 3'd4);
    end
    step();
    op_valid = 1'b0;
    if (op < 3'd4) begin
      cnt = 0;
      while (busy === 1'b1 && cnt < 100) begin
        cnt++;
        checks++;
        if (hi_out !== m_hi || lo_out !== m_lo) begin
          errors++;
          $display("FAIL %s early_commit: got %h_%h want %h_%h", name, hi_out, lo_out, m_hi, m_lo);
        end
        step();
      end
      checks++;
      if (cnt != n) begin
        errors++;
        $display("FAIL %s busy_cycles: got %0d want %0d", name, cnt, n);
      end
      m_hi = eh;
      m_lo = el;
    end else begin
      if (op == 3'd4) m_hi = a;
      if (op == 3'd5) m_lo = a;
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL %s busy_on_mt: got %b want 0", name, busy);
      end
    end
    checks++;
    if (hi_out !== m_hi || lo_out !== m_lo) begin
      errors++;
      $display("FAIL %s hilo: got %h_%h want %h_%h", name, hi_out, lo_out, m_hi, m_lo);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0 || start !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b hi=%h lo=%h start=%b want 0/0/0/0", busy, hi_out, lo_out, start);
    end
  endtask

  task automatic test_mult();
    run_op("mult_neg", 3'd0, 32'hFFFF_FFFE, 32'd3);
    checks++;
    if (hi_out !== 32'hFFFF_FFFF || lo_out !== 32'hFFFF_FFFA) begin
      errors++;
      $display("FAIL mult_const: got %h_%h want ffffffff_fffffffa", hi_out, lo_out);
    end
    run_op("multu_big", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
  endtask

  task automatic test_div();
    run_op("divu", 3'd3, 32'd100, 32'd7);
    checks++;
    if (hi_out !== 32'd2 || lo_out !== 32'd14) begin
      errors++;
      $display("FAIL divu_const: got %h_%h want 00000002_0000000e", hi_out, lo_out);
    end
    run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2);
    checks++;
    if (hi_out !== 32'hFFFF_FFFF || lo_out !== 32'hFFFF_FFFD) begin
      errors++;
      $display("FAIL div_neg_const: got %h_%h want ffffffff_fffffffd", hi_out, lo_out);
    end
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    checks++;
    if (hi_out !== 32'd0 || lo_out !== 32'h8000_0000) begin
      errors++;
      $display("FAIL div_ovf_const: got %h_%h want 00000000_80000000", hi_out, lo_out);
    end
    run_op("pre_hi", 3'd4, 32'd5, 32'd0);
    run_op("pre_lo", 3'd5, 32'd6, 32'd0);
    run_op("div_zero", 3'd2, 32'd77, 32'd0);
    checks++;
    if (hi_out !== 32'd5 || lo_out !== 32'd6) begin
      errors++;
      $display("FAIL div_zero_const: got %h_%h want 00000005_00000006", hi_out, lo_out);
    end
    run_op("divu_zero", 3'd3, 32'd9, 32'd0);
  endtask

  task automatic test_mt();
    run_op("mthi", 3'd4, 32'h1234, 32'd0);
    run_op("mtlo", 3'd5, 32'h5678, 32'd0);
    checks++;
    if (hi_out !== 32'h1234 || lo_out !== 32'h5678) begin
      errors++;
      $display("FAIL mt_const: got %h_%h want 00001234_00005678", hi_out, lo_out);
    end
  endtask

  task automatic test_cancel();
    op_valid = 1'b1;
    md_op = 3'd1;
    rs_val = 32'hDEAD_BEEF;
    rt_val = 32'h1000;
    step();
    md_op = 3'd4;
    rs_val = 32'hBAD0_0BAD;
    #1;
    checks++;
    if (start !== 1'b0) begin
      errors++;
      $display("FAIL cancel_busy_start: got %b want 0", start);
    end
    step();
    op_valid = 1'b0;
    step();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi_out !== m_hi || lo_out !== m_lo) begin
      errors++;
      $display("FAIL cancel_busy: got busy=%b %h_%h want 0 %h_%h", busy, hi_out, lo_out, m_hi, m_lo);
    end
    repeat (6) step();
    checks++;
    if (busy !== 1'b0 || hi_out !== m_hi || lo_out !== m_lo) begin
      errors++;
      $display("FAIL cancel_no_commit: got busy=%b %h_%h want 0 %h_%h", busy, hi_out, lo_out, m_hi, m_lo);
    end
    op_valid = 1'b1;
    cancel = 1'b1;
    md_op = 3'd4;
    rs_val = 32'hCAFE;
    #1;
    checks++;
    if (start !== 1'b0) begin
      errors++;
      $display("FAIL cancel_idle_start: got %b want 0", start);
    end
    step();
    md_op = 3'd0;
    step();
    op_valid = 1'b0;
    cancel = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi_out !== m_hi || lo_out !== m_lo) begin
      errors++;
      $display("FAIL cancel_idle: got busy=%b %h_%h want 0 %h_%h", busy, hi_out, lo_out, m_hi, m_lo);
    end
  endtask

  task automatic test_reset_mid();
    run_op("pre_hi2", 3'd4, 32'hAAAA, 32'd0);
    op_valid = 1'b1;
    md_op = 3'd2;
    rs_val = 32'd1000;
    rt_val = 32'd3;
    step();
    op_valid = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b %h_%h want 0 0_0", busy, hi_out, lo_out);
    end
    m_hi = 32'd0;
    m_lo = 32'd0;
    reset = 1'b1;
    step();
    run_op("b2b_mult1", 3'd0, 32'd12345, 32'hFFFF_FF00);
    run_op("b2b_mult2", 3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 1) == 1 ? $urandom : 32'($urandom_range(1, 20)));
      if ($urandom_range(0, 3) == 0) a = {a[31], 31'($urandom_range(0, 1000))};
      run_op("random", op, a, b);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mt();
    test_cancel();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
